fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with redirect/stall/advance priority.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ins_q, ins_d;
  logic        vld_q, vld_d;
  logic        do_flush, do_stall, do_adv;

  // Redirect wins over stall; advance only when neither is active.
  assign do_flush = redirect;
  assign do_stall = !redirect && stall;
  assign do_adv   = !redirect && !stall;

  always_comb begin
    pc_d  = pc_q;
    ipc_d = ipc_q;
    ins_d = ins_q;
    vld_d = vld_q;
    if (do_flush) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      ipc_d = 32'h0;
      ins_d = NOP_INSTR;
      vld_d = 1'b0;
    end else if (do_adv) begin
      pc_d  = pc_q + 32'd4;
      ipc_d = pc_q;
      ins_d = imem_instr;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ipc_q <= 32'h0;
      ins_q <= NOP_INSTR;
      vld_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ipc_q <= ipc_d;
      ins_q <= ins_d;
      vld_q <= vld_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = ipc_q;
  assign if_id_instr = ins_q;
  assign if_id_valid = vld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, scnt_q, lcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= 32'h0;
      scnt_q <= 32'h0;
      lcnt_q <= 32'h0;
    end else begin
      if (do_adv)   fcnt_q <= fcnt_q + 32'd1;
      if (do_stall) scnt_q <= scnt_q + 32'd1;
      if (do_flush) lcnt_q <= lcnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign stall_cnt = scnt_q;
  assign flush_cnt = lcnt_q;
`else
  assign fetch_cnt = 32'h0;
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected post-edge state, monitor pops and compares.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr, imem_instr, if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_instr = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc, ipc, ins;
    logic        v;
    logic [31:0] fc, sc, lc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0, n_pass = 0;

  // Reference: architectural state after each edge.
  logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_ins = NOP;
  logic        m_v = 1'b0;
  logic [31:0] m_fc = 0, m_sc = 0, m_lc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr",   imem_addr,   e.pc);
      chk("if_id_pc",    if_id_pc,    e.ipc);
      chk("if_id_instr", if_id_instr, e.ins);
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.v});
      chk("fetch_cnt",   fetch_cnt,   e.fc);
      chk("stall_cnt",   stall_cnt,   e.sc);
      chk("flush_cnt",   flush_cnt,   e.lc);
    end
  end

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    exp_t x;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    if (r) begin
      m_pc = 32'h0; m_ipc = 0; m_ins = NOP; m_v = 0; m_fc = 0; m_sc = 0; m_lc = 0;
    end else if (rd) begin
      m_pc = rpc & ~32'h3; m_ipc = 0; m_ins = NOP; m_v = 0; m_lc++;
    end else if (s) begin
      m_sc++;
    end else begin
      m_ipc = m_pc; m_ins = mem_word(m_pc); m_v = 1; m_pc = m_pc + 4; m_fc++;
    end
    x.pc = m_pc; x.ipc = m_ipc; x.ins = m_ins; x.v = m_v;
`ifdef FETCH_PERF_CNT_EN
    x.fc = m_fc; x.sc = m_sc; x.lc = m_lc;
`else
    x.fc = 0; x.sc = 0; x.lc = 0;
`endif
    q.push_back(x);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    // Reset then free-running fetch: 0,4,8,12
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    adv(4);
    // Stall while pc=8 for three cycles
    step(1, 0, 0, 0); adv(2);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    adv(2);
    // Redirect with simultaneous stall, then advance into target
    step(0, 1, 1, 32'h0000_0042); adv(2);
    // Stall right after a redirect
    step(0, 0, 1, 32'h0000_1003); step(0, 1, 0, 0); step(0, 1, 0, 0); adv(2);
    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC); adv(2);
    // Reset during stall with pc=16, reset also overriding redirect
    step(1, 0, 0, 0); adv(4); step(0, 1, 0, 0); step(1, 1, 0, 0); adv(1);
    step(0, 0, 1, 32'h80); step(1, 1, 1, 32'h200); adv(2);
    // Counter scenario: 5 advances, 2 stalls, 1 redirect
    step(1, 0, 0, 0); adv(5); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 1, 32'h30);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic r, s, rd;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      step(r, s, rd, $urandom);
    end
    @(negedge clk); rst = 0; stall = 1; redirect = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
